// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg: shared word, RAM-state and arbiter-state types for the caches.
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  localparam int WORD_W       = 32;
  localparam int STARVE_CNT_W = 4;

  typedef logic [WORD_W-1:0]       word_t;
  typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // A write beats a read when the dcache raises both.
  function automatic logic dcache_wants_ram(input logic ren, input logic wen);
    return ren | wen;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_mem_arbiter_if.sv
// ============================================================================
// cache_mem_arbiter_if: cache-side request/response and RAM-side bus bundle.
// Rev 1.0
// ============================================================================
`default_nettype none

interface cache_mem_arbiter_if;
  import cpu_types_pkg::*;

  // icache side
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  // dcache side
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ramerr;

  // The arbiter is the single master of the RAM port.
  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  // Caches and RAM model as seen from outside the arbiter.
  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

endinterface

`default_nettype wire

// File: rtl/starve_counter.sv
// ============================================================================
// starve_counter: saturating count of dcache wins while icache is waiting.
// Rev 1.0
// ============================================================================
`default_nettype none

module starve_counter
  import cpu_types_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam starve_cnt_t LIMIT_CNT = starve_cnt_t'(LIMIT);

  starve_cnt_t count;

  // Clear wins over increment; the two are never requested together.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count < LIMIT_CNT)) begin
      count <= count + starve_cnt_t'(1);
    end
  end

  assign at_limit = (count >= LIMIT_CNT);

endmodule

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// cache_mem_arbiter: dcache-priority RAM arbiter with bounded icache starvation.
// Rev 1.0
// ============================================================================
`default_nettype none

module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  cache_mem_arbiter_if.master bus
);

  arb_state_t state;
  arb_state_t state_next;
  arb_state_t cur_state;

  logic  d_req;
  logic  starved;
  logic  starve_inc;
  logic  starve_clr;

  logic  ren;
  logic  wen;
  word_t addr;
  word_t store;
  logic  iwait;
  logic  dwait;
  logic  err;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (CLK),
    .rst      (RST),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starved)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Reset masks the registered state so an abandoned access can never
  // flash a wait-low or an enable during the reset cycle itself.
  assign cur_state = RST ? IDLE : state;
  assign d_req     = dcache_wants_ram(bus.dREN, bus.dWEN);

  always_comb begin
    state_next = cur_state;
    ren        = 1'b0;
    wen        = 1'b0;
    addr       = '0;
    store      = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    err        = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;

    case (cur_state)
      IDLE: begin
        starve_clr = ~bus.iREN;
        if (d_req && !starved) begin
          state_next = DGRANT;
        end else if (bus.iREN) begin
          state_next = IGRANT;
        end else if (d_req) begin
          state_next = DGRANT;
        end
      end

      IGRANT: begin
        ren  = bus.iREN;
        addr = bus.iaddr;
        if (!bus.iREN) begin
          state_next = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          iwait      = 1'b0;
          starve_clr = 1'b1;
          state_next = IDLE;
        end else if (bus.ramstate == ERROR) begin
          err        = 1'b1;
          state_next = IDLE;
        end
      end

      DGRANT: begin
        wen   = bus.dWEN;
        ren   = bus.dREN & ~bus.dWEN;
        addr  = bus.daddr;
        store = bus.dstore;
        if (!d_req) begin
          state_next = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          dwait      = 1'b0;
          starve_inc = bus.iREN;
          state_next = IDLE;
        end else if (bus.ramstate == ERROR) begin
          err        = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.ramREN   = ren;
  assign bus.ramWEN   = wen;
  assign bus.ramaddr  = addr;
  assign bus.ramstore = store;
  assign bus.ramerr   = err;
  assign bus.iwait    = iwait;
  assign bus.dwait    = dwait;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
// tb_cache_mem_arbiter: directed scenarios plus random traffic vs. an ownership model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT    = 4;
  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter #(
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: who owns the RAM port and how long icache has waited.
  logic  model_on = 1'b0;
  int    m_owner  = OWN_NONE;
  int    m_starve = 0;
  int    n_owner  = OWN_NONE;
  int    n_starve = 0;
  logic  e_iwait, e_dwait, e_ren, e_wen, e_err, m_dreq;
  word_t e_addr, e_store;
  arb_state_t e_state;

  always @(negedge CLK) begin
    if (model_on) begin
      e_iwait  = 1'b1;
      e_dwait  = 1'b1;
      e_ren    = 1'b0;
      e_wen    = 1'b0;
      e_err    = 1'b0;
      e_addr   = '0;
      e_store  = '0;
      n_owner  = m_owner;
      n_starve = m_starve;
      m_dreq   = bus.dREN | bus.dWEN;
      e_state  = (m_owner == OWN_I) ? IGRANT : (m_owner == OWN_D) ? DGRANT : IDLE;

      if (RST) begin
        n_owner  = OWN_NONE;
        n_starve = 0;
      end else if (m_owner == OWN_NONE) begin
        if (m_dreq && m_starve < LIMIT) n_owner = OWN_D;
        else if (bus.iREN)              n_owner = OWN_I;
        else if (m_dreq)                n_owner = OWN_D;
        if (!bus.iREN) n_starve = 0;
      end else if (m_owner == OWN_I) begin
        e_ren  = bus.iREN;
        e_addr = bus.iaddr;
        if (!bus.iREN) begin
          n_owner = OWN_NONE;
        end else if (bus.ramstate == ACCESS) begin
          e_iwait  = 1'b0;
          n_owner  = OWN_NONE;
          n_starve = 0;
        end else if (bus.ramstate == ERROR) begin
          e_err   = 1'b1;
          n_owner = OWN_NONE;
        end
      end else begin
        e_wen   = bus.dWEN;
        e_ren   = bus.dREN && !bus.dWEN;
        e_addr  = bus.daddr;
        e_store = bus.dstore;
        if (!m_dreq) begin
          n_owner = OWN_NONE;
        end else if (bus.ramstate == ACCESS) begin
          e_dwait = 1'b0;
          n_owner = OWN_NONE;
          if (bus.iREN) n_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        end else if (bus.ramstate == ERROR) begin
          e_err   = 1'b1;
          n_owner = OWN_NONE;
        end
      end

      chk("m_iwait",    bus.iwait,    e_iwait);
      chk("m_dwait",    bus.dwait,    e_dwait);
      chk("m_ramREN",   bus.ramREN,   e_ren);
      chk("m_ramWEN",   bus.ramWEN,   e_wen);
      chk("m_ramaddr",  bus.ramaddr,  e_addr);
      chk("m_ramstore", bus.ramstore, e_store);
      chk("m_ramerr",   bus.ramerr,   e_err);
      chk("m_state",    dut.state,    e_state);
      chk("m_starve",   dut.u_starve.count, m_starve);
      if (!e_iwait) chk("m_iload", bus.iload, bus.ramload);
      if (!e_dwait) chk("m_dload", bus.dload, bus.ramload);
    end
  end

  always @(posedge CLK) begin
    m_owner  = n_owner;
    m_starve = n_starve;
  end

  int dcount;
  logic got_i;
  int r;

  initial begin
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
    @(posedge CLK);
    model_on = 1'b1;
    tick(); tick();
    RST = 1'b0;

    // Reset state
    @(negedge CLK);
    chk("rst_state", dut.state, IDLE);
    chk("rst_iwait", bus.iwait, 1);
    chk("rst_dwait", bus.dwait, 1);
    chk("rst_ramREN", bus.ramREN, 0);

    // Icache only: completion two cycles after the request
    tick(); bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = FREE;
    @(negedge CLK);
    chk("ic_arb_iwait", bus.iwait, 1);
    chk("ic_arb_ramREN", bus.ramREN, 0);
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    @(negedge CLK);
    chk("ic_iwait", bus.iwait, 0);
    chk("ic_iload", bus.iload, 32'hDEADBEEF);
    chk("ic_dwait", bus.dwait, 1);
    chk("ic_ramaddr", bus.ramaddr, 32'h40);
    tick(); bus.iREN = 0; bus.ramstate = FREE;
    @(negedge CLK);
    chk("ic_back_idle", dut.state, IDLE);

    // Simultaneous: dcache first, then icache after an IDLE cycle
    tick(); bus.iREN = 1; bus.dREN = 1; bus.daddr = 32'h100; bus.ramstate = ACCESS;
    @(negedge CLK);
    chk("sim_idle", dut.state, IDLE);
    tick();
    @(negedge CLK);
    chk("sim_dgrant", dut.state, DGRANT);
    chk("sim_dwait", bus.dwait, 0);
    chk("sim_iwait_hi", bus.iwait, 1);
    tick(); bus.dREN = 0;
    @(negedge CLK);
    chk("sim_pass_idle", dut.state, IDLE);
    tick();
    @(negedge CLK);
    chk("sim_igrant", dut.state, IGRANT);
    chk("sim_iwait", bus.iwait, 0);
    tick(); bus.iREN = 0; bus.ramstate = FREE;

    // Dcache write with two BUSY cycles
    tick(); bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h12345678; bus.ramstate = BUSY;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) bus.ramstate = ACCESS;
      @(negedge CLK);
      chk($sformatf("wr_ramWEN%0d", k), bus.ramWEN, 1);
      chk($sformatf("wr_ramREN%0d", k), bus.ramREN, 0);
      chk($sformatf("wr_addr%0d", k), bus.ramaddr, 32'h80);
      chk($sformatf("wr_store%0d", k), bus.ramstore, 32'h12345678);
      chk($sformatf("wr_dwait%0d", k), bus.dwait, (k == 2) ? 1'b0 : 1'b1);
    end
    tick(); bus.dWEN = 0; bus.ramstate = FREE;

    // Starvation guard
    tick(); bus.iREN = 1; bus.dREN = 1; bus.daddr = 32'h300; bus.iaddr = 32'h500;
    bus.ramstate = ACCESS;
    dcount = 0; got_i = 0;
    for (int c = 0; c < 40 && !got_i; c++) begin
      @(negedge CLK);
      if (bus.dwait == 1'b0) dcount++;
      if (bus.iwait == 1'b0) got_i = 1'b1;
      if (!got_i) tick();
    end
    chk("starve_igrant_seen", got_i, 1);
    chk("starve_dcount", dcount, LIMIT);
    tick();
    @(negedge CLK);
    chk("starve_cleared", dut.u_starve.count, 0);
    tick(); bus.iREN = 0; bus.dREN = 0; bus.ramstate = FREE;

    // ERROR during DGRANT, then retry
    tick(); bus.dREN = 1; bus.daddr = 32'h200; bus.ramstate = ERROR;
    @(negedge CLK);
    chk("err_idle_noerr", bus.ramerr, 0);
    tick();
    @(negedge CLK);
    chk("err_state", dut.state, DGRANT);
    chk("err_ramerr", bus.ramerr, 1);
    chk("err_dwait", bus.dwait, 1);
    tick(); bus.ramstate = ACCESS;
    @(negedge CLK);
    chk("err_idle", dut.state, IDLE);
    chk("err_pulse_end", bus.ramerr, 0);
    tick();
    @(negedge CLK);
    chk("err_regrant", dut.state, DGRANT);
    chk("err_retry_dwait", bus.dwait, 0);
    tick(); bus.dREN = 0; bus.ramstate = FREE;

    // icache withdraws mid-grant
    tick(); bus.iREN = 1; bus.iaddr = 32'h44; bus.ramstate = BUSY;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("wd_igrant", dut.state, IGRANT);
    chk("wd_ramREN1", bus.ramREN, 1);
    tick(); bus.iREN = 0;
    @(negedge CLK);
    chk("wd_ramREN0", bus.ramREN, 0);
    chk("wd_iwait", bus.iwait, 1);
    tick();
    @(negedge CLK);
    chk("wd_idle", dut.state, IDLE);

    // Reset during a BUSY dcache access
    tick(); bus.dREN = 1; bus.daddr = 32'h600; bus.ramstate = BUSY;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("rm_dgrant", dut.state, DGRANT);
    tick(); RST = 1; bus.ramstate = ACCESS;
    @(negedge CLK);
    chk("rm_rst_dwait", bus.dwait, 1);
    tick(); RST = 0; bus.ramstate = BUSY;
    @(negedge CLK);
    chk("rm_idle", dut.state, IDLE);
    chk("rm_ramREN", bus.ramREN, 0);
    chk("rm_ramWEN", bus.ramWEN, 0);
    chk("rm_iwait", bus.iwait, 1);
    chk("rm_dwait", bus.dwait, 1);
    tick(); bus.dREN = 0;

    // Random traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if ($urandom_range(0, 3) == 0) bus.iREN = ~bus.iREN;
      if (cyc >= 1000 && cyc < 1500) bus.iREN = 1'b1;
      if ($urandom_range(0, 3) == 0) bus.dREN = ~bus.dREN;
      if ($urandom_range(0, 5) == 0) bus.dWEN = ~bus.dWEN;
      if ($urandom_range(0, 7) == 0) bus.iaddr = $urandom;
      if ($urandom_range(0, 7) == 0) bus.daddr = $urandom;
      if ($urandom_range(0, 7) == 0) bus.dstore = $urandom;
      bus.ramload = $urandom;
      r = $urandom_range(0, 99);
      if (r < 25)      bus.ramstate = FREE;
      else if (r < 50) bus.ramstate = BUSY;
      else if (r < 90) bus.ramstate = ACCESS;
      else             bus.ramstate = ERROR;
      RST = ($urandom_range(0, 199) == 0);
    end
    tick(); RST = 0;
    tick();
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
